// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin Avalon-MM arbiter in front of a single-port on-chip RAM.
// Read data returns to its owner through a two-stage tag pipeline; sticky flags report misuse.
module onchip_mem_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 10000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,
    input  logic                err_clear,
    output logic                oob_err,
    output logic                proto_err
);
    localparam int BE_W = DATA_W / 8;

    logic                r_run;
    logic                r_last_grant;
    logic [ADDR_W-1:0]   r_hold_addr;
    logic [BE_W-1:0]     r_hold_be;
    logic [DATA_W-1:0]   r_hold_wdata;
    logic                r_s1_valid;
    logic                r_s1_owner;
    logic                r_s1_oob;
    logic                r_rdv0;
    logic                r_rdv1;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;
    logic                r_oob_err;
    logic                r_proto_err;

    logic                w_req0;
    logic                w_req1;
    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_gnt_any;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [BE_W-1:0]     w_sel_be;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_sel_read;
    logic                w_sel_write;
    logic                w_in_range;
    logic                w_rd_issue;
    logic                w_oob_set;
    logic                w_proto_set;
    logic [DATA_W-1:0]   w_s1_data;

    // Round-robin grant and selection of the winning master's request fields.
    always_comb begin
        w_req0      = m0_read | m0_write;
        w_req1      = m1_read | m1_write;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_sel_addr  = r_hold_addr;
        w_sel_be    = r_hold_be;
        w_sel_wdata = r_hold_wdata;
        w_sel_read  = 1'b0;
        w_sel_write = 1'b0;
        // r_last_grant=1 means m1 won last, so m0 wins the next conflict.
        if (r_run) begin
            w_gnt0 = w_req0 & (~w_req1 | r_last_grant);
            w_gnt1 = w_req1 & (~w_req0 | ~r_last_grant);
        end else begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
        if (w_gnt0) begin
            w_sel_addr  = m0_address;
            w_sel_be    = m0_byteenable;
            w_sel_wdata = m0_writedata;
            w_sel_read  = m0_read;
            w_sel_write = m0_write;
        end else if (w_gnt1) begin
            w_sel_addr  = m1_address;
            w_sel_be    = m1_byteenable;
            w_sel_wdata = m1_writedata;
            w_sel_read  = m1_read;
            w_sel_write = m1_write;
        end else begin
            w_sel_read  = 1'b0;
            w_sel_write = 1'b0;
        end
        w_gnt_any   = w_gnt0 | w_gnt1;
        w_in_range  = (32'(w_sel_addr) < 32'(DEPTH));
        w_rd_issue  = w_gnt_any & w_sel_read & ~w_sel_write;
        w_oob_set   = w_gnt_any & ~w_in_range;
        w_proto_set = (w_gnt0 & m0_read & m0_write) | (w_gnt1 & m1_read & m1_write);
        w_s1_data   = r_s1_oob ? {DATA_W{1'b0}} : mem_readdata;
    end

    // Grant history and the RAM-side fields held while nobody is granted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run        <= 1'b0;
            r_last_grant <= 1'b1;
            r_hold_addr  <= '0;
            r_hold_be    <= '0;
            r_hold_wdata <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_gnt_any) begin
                r_last_grant <= w_gnt1;
                r_hold_addr  <= w_sel_addr;
                r_hold_be    <= w_sel_be;
                r_hold_wdata <= w_sel_wdata;
            end
        end
    end

    // Tag pipeline: stage 1 tracks the owner, stage 2 registers the returned word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_owner <= 1'b0;
            r_s1_oob   <= 1'b0;
            r_rdv0     <= 1'b0;
            r_rdv1     <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            r_s1_valid <= w_rd_issue;
            r_s1_owner <= w_gnt1;
            r_s1_oob   <= ~w_in_range;
            r_rdv0     <= r_s1_valid & ~r_s1_owner;
            r_rdv1     <= r_s1_valid & r_s1_owner;
            if (r_s1_valid && r_s1_owner) begin
                r_rdata1 <= w_s1_data;
            end else if (r_s1_valid) begin
                r_rdata0 <= w_s1_data;
            end
        end
    end

    // Sticky error flags; a clear wins over a set in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_oob_err   <= 1'b0;
            r_proto_err <= 1'b0;
        end else if (err_clear) begin
            r_oob_err   <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_oob_err   <= r_oob_err | w_oob_set;
            r_proto_err <= r_proto_err | w_proto_set;
        end
    end

    assign m0_waitrequest   = ~r_run | (w_req0 & ~w_gnt0);
    assign m1_waitrequest   = ~r_run | (w_req1 & ~w_gnt1);
    assign m0_readdata      = r_rdata0;
    assign m1_readdata      = r_rdata1;
    assign m0_readdatavalid = r_rdv0;
    assign m1_readdatavalid = r_rdv1;
    assign mem_address      = w_sel_addr;
    assign mem_byteenable   = w_sel_be;
    assign mem_writedata    = w_sel_wdata;
    assign mem_chipselect   = w_gnt_any & w_in_range;
    assign mem_write        = w_gnt_any & w_sel_write & w_in_range;
    assign mem_clken        = r_run;
    assign oob_err          = r_oob_err;
    assign proto_err        = r_proto_err;
endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Two-master Avalon-MM arbiter in front of the single-port on-chip RAM slave: 32-bit data, 4-bit byteenable, 14-bit word address, 10000 words.
- Lets two requesters share the one RAM port, for example the Nios II data master and a DMA/peripheral master.
- Grants one transfer per cycle using round-robin priority.
- Routes the RAM's 1-cycle read data back to the owning master with a tag pipeline, and flags out-of-range and illegal accesses.

Parameters:
- ADDR_W, 14, word address width on both master ports and the RAM port.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- DEPTH, 10000, number of valid words; addresses >= DEPTH are out of range.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- m0_address  in  ADDR_W  master 0 word address
- m0_byteenable  in  DATA_W/8  master 0 byte lanes
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_writedata  in  DATA_W  master 0 write data
- m0_waitrequest  out  1  master 0 stall
- m0_readdata  out  DATA_W  master 0 read data
- m0_readdatavalid  out  1  master 0 read data strobe
- m1_*  same eight signals as m0_*, for master 1
- mem_address  out  ADDR_W  RAM address
- mem_byteenable  out  DATA_W/8  RAM byte lanes
- mem_chipselect  out  1  RAM select
- mem_write  out  1  RAM write (the RAM forms wren from chipselect & write)
- mem_writedata  out  DATA_W  RAM write data
- mem_clken  out  1  RAM clock enable
- mem_readdata  in  DATA_W  RAM read data, valid the cycle after the address
- err_clear  in  1  synchronous clear of the sticky error flags
- oob_err  out  1  sticky: an out-of-range access occurred
- proto_err  out  1  sticky: read and write asserted together on one master

Behaviour:
- Reset (reset_n low, async):
  - last_grant=1, so m0 wins the first conflict.
  - Tag pipeline cleared; readdatavalid 0 on both masters; readdata 0.
  - oob_err=0, proto_err=0.
  - mem_clken=0, mem_chipselect=0, mem_write=0.
  - waitrequest=1 on both masters.
- Out of reset, mem_clken=1 constantly.
- Requests and grant:
  - req_i = mi_read | mi_write.
  - Grant is combinational in the same cycle.
  - If only one master requests, it is granted.
  - If both request, the master other than last_grant is granted.
  - last_grant is updated on every grant.
  - mi_waitrequest = req_i & ~grant_i. An idle master sees waitrequest=0.
- Issue:
  - The granted master's address, byteenable and writedata drive mem_*.
  - mem_chipselect = grant_any & in_range.
  - mem_write = granted write & in_range.
  - When no master is granted, mem_* hold their last values with chipselect=0 and write=0.
- Simultaneous read and write on one master:
  - Treated as a write; no readdatavalid is produced.
  - proto_err is set.
- Read latency is fixed at 2 cycles:
  - Read accepted in cycle N.
  - At N+1 the tag stage captures mem_readdata (or 0 if out of range).
  - In cycle N+2, mi_readdatavalid=1 for exactly one cycle with registered mi_readdata.
  - The non-owner's readdatavalid stays 0 and its readdata holds its last value.
- Pipelining:
  - Back-to-back reads, one per cycle, from either or both masters are fully pipelined and return in issue order.
  - The arbiter never stalls for outstanding reads.
- Writes complete in the accept cycle and have no response.
- Out-of-range access (address >= DEPTH):
  - No RAM access is made.
  - A read still returns readdatavalid with data 0.
  - oob_err is set.
- Error flags:
  - err_clear has priority over a set occurring in the same cycle.
- Read-during-write:
  - Write then read to the same address in consecutive cycles returns the new data.
  - Same-cycle collision is impossible, because only one access is issued per cycle.
- Reset asserted mid-transfer:
  - Outstanding read responses are discarded; none are emitted after reset.

Test Plan:
- m0 writes 0xA5A5_1234 to addr 0x0010 with byteenable 0xF, then reads addr 0x0010 -> no waitrequest; m0_readdatavalid exactly 2 cycles after the read accept with 0xA5A5_1234; m1_readdatavalid stays 0.
- Byte lanes: write 0xFFFF_FFFF to 0x0020, then 0x0000_0000 with byteenable 0x5, then read -> 0xFF00_FF00.
- Both masters assert reads continuously for 8 cycles, m0 to 0x0001, m1 to 0x0002:
  - Grants alternate m0,m1,m0,…, starting with m0 after reset.
  - Each master sees 4 accepts, and waitrequest=1 on its losing cycles.
  - Each master sees 4 readdatavalids carrying the correct data, in order.
- m1 reads addr 10000 (0x2710) -> mem_chipselect=0; m1_readdatavalid with 0x0000_0000; oob_err=1 until err_clear; err_clear and a new OOB access in the same cycle -> oob_err=0.
- m0 asserts read and write together to 0x0030 with 0x1111_1111 -> location written; no readdatavalid; proto_err=1.
- Issue a read, then drop reset_n one cycle later -> no readdatavalid appears after reset; all outputs at reset values; first conflict after release is granted to m0.
